// File: rtl/i2c_line_conditioner.sv
// i2c_line_conditioner: synchronizes and glitch-filters raw SDA/SCL pads,
// then derives edge pulses and START/STOP condition pulses from the filtered lines.
module i2c_line_conditioner #(
    parameter int SYNC_STAGES  = 2,
    parameter int FILTER_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    SDA_in,
    input  logic                    SCL_in,
    input  logic [FILTER_WIDTH-1:0] filter_len,
    output logic                    SDA_sync,
    output logic                    SCL_sync,
    output logic                    SDA_rise,
    output logic                    SDA_fall,
    output logic                    SCL_rise,
    output logic                    SCL_fall,
    output logic                    start_detect,
    output logic                    stop_detect
);
    logic [1:0]              w_raw;
    logic [1:0]              w_f;
    logic [1:0]              r_p;
    logic [FILTER_WIDTH-1:0] w_len;

    assign w_raw = {SCL_in, SDA_in};
    assign w_len = (filter_len == '0) ? FILTER_WIDTH'(1) : filter_len;

    // Bit 0 is SDA, bit 1 is SCL; both lines idle high out of reset.
    for (genvar l = 0; l < 2; l++) begin : g_line
        logic [SYNC_STAGES-1:0]  r_sync;
        logic [FILTER_WIDTH-1:0] r_cnt;
        logic                    r_f;
        logic                    w_s;
        logic [FILTER_WIDTH:0]   w_next;

        assign w_s    = r_sync[SYNC_STAGES-1];
        assign w_next = {1'b0, r_cnt} + 1'b1;
        assign w_f[l] = r_f;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync <= '1;
                r_f    <= 1'b1;
                r_cnt  <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[l]};
                if (w_s == r_f)
                    r_cnt <= '0;
                else if (w_next >= {1'b0, w_len}) begin
                    r_f   <= w_s;
                    r_cnt <= '0;
                end else if (r_cnt != '1)
                    r_cnt <= w_next[FILTER_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_p <= 2'b11;
        else
            r_p <= w_f;
    end

    assign SDA_sync     = w_f[0];
    assign SCL_sync     = w_f[1];
    assign SDA_rise     = w_f[0] & ~r_p[0];
    assign SDA_fall     = ~w_f[0] & r_p[0];
    assign SCL_rise     = w_f[1] & ~r_p[1];
    assign SCL_fall     = ~w_f[1] & r_p[1];
    // Requiring SCL stable high over both cycles rejects simultaneous SDA/SCL changes.
    assign start_detect = SDA_fall & w_f[1] & r_p[1];
    assign stop_detect  = SDA_rise & w_f[1] & r_p[1];
endmodule

// File: tb/tb_i2c_line_conditioner.sv
// tb_i2c_line_conditioner: directed stimulus pushes expected pulse events into a queue;
// a negedge monitor pops and compares whenever any pulse output is high.
module tb_i2c_line_conditioner;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       SDA_in = 1'b1;
    logic       SCL_in = 1'b1;
    logic [3:0] filter_len = 4'd4;
    logic       SDA_sync, SCL_sync, SDA_rise, SDA_fall, SCL_rise, SCL_fall;
    logic       start_detect, stop_detect;

    typedef struct {
        int         cyc;
        logic [5:0] pul;
        logic [1:0] lvl;
    } ev_t;

    // Pulse vector order: {SDA_rise, SDA_fall, SCL_rise, SCL_fall, start, stop}
    localparam logic [5:0] P_SR = 6'b100000;
    localparam logic [5:0] P_SF = 6'b010000;
    localparam logic [5:0] P_CR = 6'b001000;
    localparam logic [5:0] P_CF = 6'b000100;
    localparam logic [5:0] P_ST = 6'b000010;
    localparam logic [5:0] P_SP = 6'b000001;

    ev_t        q[$];
    ev_t        m_e;
    logic [5:0] m_pul;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         t0;

    i2c_line_conditioner #(.SYNC_STAGES(2), .FILTER_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .SDA_in(SDA_in), .SCL_in(SCL_in), .filter_len(filter_len),
        .SDA_sync(SDA_sync), .SCL_sync(SCL_sync), .SDA_rise(SDA_rise), .SDA_fall(SDA_fall),
        .SCL_rise(SCL_rise), .SCL_fall(SCL_fall), .start_detect(start_detect),
        .stop_detect(stop_detect)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        m_pul = {SDA_rise, SDA_fall, SCL_rise, SCL_fall, start_detect, stop_detect};
        if (m_pul != 6'b0) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse cyc=%0d got=%b expected none", cyc, m_pul);
            end else begin
                m_e = q.pop_front();
                if (m_e.cyc != cyc || m_e.pul != m_pul || m_e.lvl != {SDA_sync, SCL_sync}) begin
                    errors++;
                    $display("FAIL pulse_event got cyc=%0d pul=%b lvl=%b expected cyc=%0d pul=%b lvl=%b",
                             cyc, m_pul, {SDA_sync, SCL_sync}, m_e.cyc, m_e.pul, m_e.lvl);
                end
            end
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int dc, input logic [5:0] p, input logic [1:0] lvl);
        ev_t e;
        e.cyc = cyc + dc;
        e.pul = p;
        e.lvl = lvl;
        q.push_back(e);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        wait_n(2);
        rst = 1'b0;
        chk("reset_sda", SDA_sync, 1'b1);
        chk("reset_scl", SCL_sync, 1'b1);
        wait_n(20);
        chk("idle_sda", SDA_sync, 1'b1);
        chk("idle_scl", SCL_sync, 1'b1);

        // 3-cycle glitch with L=4 must be swallowed
        filter_len = 4'd4;
        SDA_in = 1'b0;
        wait_n(3);
        SDA_in = 1'b1;
        wait_n(10);
        chk("glitch_sda", SDA_sync, 1'b1);

        // Held low: fall at edge 2+4, START since SCL high
        expect_ev(6, P_SF | P_ST, 2'b01);
        SDA_in = 1'b0;
        wait_n(12);
        chk("start_sda", SDA_sync, 1'b0);

        // L=1: rise at edge 3 gives STOP
        filter_len = 4'd1;
        expect_ev(3, P_SR | P_SP, 2'b11);
        SDA_in = 1'b1;
        wait_n(8);

        // SCL low, SDA toggles: edge pulses only
        expect_ev(3, P_CF, 2'b10);
        SCL_in = 1'b0;
        wait_n(8);
        for (int i = 0; i < 4; i++) begin
            expect_ev(3, (i % 2 == 0) ? P_SF : P_SR, (i % 2 == 0) ? 2'b00 : 2'b10);
            SDA_in = (i % 2 != 0);
            wait_n(6);
        end
        chk("toggle_sda", SDA_sync, 1'b1);
        chk("toggle_scl", SCL_sync, 1'b0);
        expect_ev(3, P_CR, 2'b11);
        SCL_in = 1'b1;
        wait_n(8);

        // Simultaneous changes: no START/STOP
        expect_ev(3, P_SF | P_CF, 2'b00);
        SDA_in = 1'b0;
        SCL_in = 1'b0;
        wait_n(8);
        expect_ev(3, P_SR | P_CR, 2'b11);
        SDA_in = 1'b1;
        SCL_in = 1'b1;
        wait_n(8);

        // filter_len=0 behaves as 1
        filter_len = 4'd0;
        expect_ev(3, P_SF | P_ST, 2'b01);
        SDA_in = 1'b0;
        wait_n(8);
        expect_ev(3, P_SR | P_SP, 2'b11);
        SDA_in = 1'b1;
        wait_n(8);

        // Mid-operation reset discards pending count; relaunch after release
        filter_len = 4'd8;
        SDA_in = 1'b0;
        wait_n(5);
        rst = 1'b1;
        #1;
        chk("midrst_sda", SDA_sync, 1'b1);
        chk("midrst_scl", SCL_sync, 1'b1);
        wait_n(1);
        rst = 1'b0;
        expect_ev(10, P_SF | P_ST, 2'b01);
        wait_n(9);
        chk("pre_release_fall_sda", SDA_sync, 1'b1);
        wait_n(6);
        chk("post_reset_sda", SDA_sync, 1'b0);

        // Shrinking filter_len below accumulated count updates on the next mismatch cycle
        t0 = cyc;
        SDA_in = 1'b1;
        wait_n(6);
        filter_len = 4'd2;
        expect_ev(t0 + 7 - cyc, P_SR | P_SP, 2'b11);
        wait_n(8);
        chk("shrink_sda", SDA_sync, 1'b1);

        wait_n(5);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_events got pending=%0d expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
